// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes LANES bytes of a 128-bit state per cycle,
// forward or (optionally) inverse S-box, with valid/ready on both sides.
module sub_bytes_iter #(
    parameter int LANES      = 4,
    parameter int ENABLE_INV = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam bit LANES_OK = (LANES == 1) || (LANES == 2) || (LANES == 4) ||
                              (LANES == 8) || (LANES == 16);

    if (!LANES_OK) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic       INV_EN = (ENABLE_INV != 0);
    localparam logic [3:0] STEP   = 4'(LANES % 16);
    localparam logic [3:0] LAST   = 4'(16 - LANES);

    // Byte b lives at bits [8*(255-b) +: 8] so the literal reads like the FIPS-197 table.
    localparam logic [2047:0] SBOX_F = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t       state_q;
    logic [127:0] work_q, work_d;
    logic [3:0]   cnt_q;
    logic         mode_q;
    logic         in_ready_q, out_valid_q, busy_q;

    logic [LANES-1:0][7:0] lane_in, fwd_b, inv_b, lane_out;

    // Lane index wraps mod 16, so the group select can never leave the state.
    always_comb begin
        logic [3:0] idx;
        work_d  = work_q;
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            idx        = cnt_q + 4'(l);
            lane_in[l] = work_q[8*idx +: 8];
            work_d[8*idx +: 8] = lane_out[l];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_fwd
        assign fwd_b[l] = SBOX_F[8*(255-int'(lane_in[l])) +: 8];
    end

    if (ENABLE_INV != 0) begin : g_inv
        localparam logic [2047:0] SBOX_I = 2048'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb_547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125_72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84_90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b_3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e_47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4_1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef_a0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d;
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign inv_b[l] = SBOX_I[8*(255-int'(lane_in[l])) +: 8];
        end
    end else begin : g_no_inv
        assign inv_b = fwd_b;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_mux
        assign lane_out[l] = mode_q ? inv_b[l] : fwd_b[l];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    work_q     <= in_data;
                    mode_q     <= in_inv & INV_EN;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= PROC;
                end
                PROC: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + STEP;
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: six builds (LANES 4/1/2/8/16, plus forward-only),
// S-box model derived from GF(2^8) inversion + affine map, scoreboard queue.
module tb_sub_bytes_iter;

    localparam int NDUT = 6;
    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NDUT-1:0]            in_valid = '0;
    logic [NDUT-1:0]            in_ready, out_valid, busy;
    logic [127:0]               in_data = '0;
    logic                       in_inv = 1'b0;
    logic                       out_ready = 1'b0;
    logic [NDUT-1:0][127:0]     out_data;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q[$];
    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_iter #(
            .LANES     (g == 1 ? 1 : g == 2 ? 2 : g == 3 ? 8 : g == 4 ? 16 : 4),
            .ENABLE_INV(g == 5 ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .in_inv   (in_inv),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    function automatic int lat_of(int s);
        case (s)
            1: return 16;
            2: return 8;
            3: return 2;
            4: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_model();
        logic [7:0] r, x, s;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gmul(r, x);
            if (v == 0) r = 8'h00;
            s = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
            fwd_m[v] = s;
            inv_m[s] = x;
        end
    endtask

    function automatic logic [127:0] model(logic [127:0] d, logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
        return r;
    endfunction

    // Accept one state on DUT s, push exp, wait for out_valid and check latency.
    task automatic send(int s, logic [127:0] d, logic inv, logic [127:0] exp, string nm);
        int n;
        logic bad;
        n = 0;
        while (!in_ready[s] && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (in_ready[s] !== 1'b1) begin
            errors++; $display("FAIL %s ready: in_ready=%b required 1", nm, in_ready[s]);
        end
        in_data = d; in_inv = inv; in_valid[s] = 1'b1;
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid[s] = 1'b0; in_data = ~d; in_inv = ~inv;
        n = 0; bad = 1'b0;
        while (out_valid[s] !== 1'b1 && n < 40) begin
            if (in_ready[s] !== 1'b0 || busy[s] !== 1'b1) bad = 1'b1;
            @(negedge clk); n++;
        end
        checks++;
        if (n != lat_of(s)) begin
            errors++; $display("FAIL %s latency: got %0d cycles required %0d", nm, n, lat_of(s));
        end
        checks++;
        if (bad || in_ready[s] !== 1'b0) begin
            errors++; $display("FAIL %s proc_flags: in_ready/busy wrong during PROC, in_ready=%b", nm, in_ready[s]);
        end
    endtask

    task automatic drain(int s, string nm);
        logic [127:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL %s scoreboard: empty queue at output", nm);
            exp = 'x;
        end else exp = sb_q.pop_front();
        if (out_data[s] !== exp) begin
            errors++; $display("FAIL %s data: got %h required %h", nm, out_data[s], exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid[s] !== 1'b0 || in_ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
            errors++; $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                               nm, out_valid[s], in_ready[s], busy[s]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < NDUT; s++) begin
            checks++;
            if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 || busy[s] !== 1'b0 || out_data[s] !== '0) begin
                errors++; $display("FAIL reset dut%0d: rdy=%b vld=%b busy=%b data=%h required 1 0 0 0",
                                   s, in_ready[s], out_valid[s], busy[s], out_data[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        send(0, APPB_IN, 1'b0, APPB_OUT, "fwd_appb");
        drain(0, "fwd_appb");
    endtask

    task automatic test_inverse();
        send(0, APPB_OUT, 1'b1, APPB_IN, "inv_appb");
        drain(0, "inv_appb");
        send(0, '0, 1'b0, {16{8'h63}}, "fwd_zero");
        drain(0, "fwd_zero");
        send(0, {16{8'h63}}, 1'b1, '0, "inv_63");
        drain(0, "inv_63");
    endtask

    // Walk every byte value through both tables.
    task automatic test_full_table();
        logic [127:0] d;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(t*16 + i);
            send(0, d, 1'b0, model(d, 1'b0), "tbl_fwd");
            drain(0, "tbl_fwd");
            send(0, d, 1'b1, model(d, 1'b1), "tbl_inv");
            drain(0, "tbl_inv");
        end
    endtask

    task automatic test_sweep();
        for (int s = 1; s <= 4; s++) begin
            send(s, APPB_IN, 1'b0, APPB_OUT, $sformatf("sweep_l%0d", 16 / lat_of(s)));
            drain(s, $sformatf("sweep_l%0d", 16 / lat_of(s)));
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] first_exp, second;
        logic bad;
        first_exp = model(APPB_IN, 1'b0) ^ 128'h0;
        second = 128'h0123456789abcdeffedcba9876543210;
        send(0, APPB_IN, 1'b0, APPB_OUT, "bp_first");
        in_data = second; in_inv = 1'b0; in_valid[0] = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== APPB_OUT) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold: vld=%b rdy=%b data=%h required 1 0 %h",
                               out_valid[0], in_ready[0], out_data[0], APPB_OUT);
        end
        drain(0, "bp_first");
        @(posedge clk);
        sb_q.push_back(model(second, 1'b0));
        @(negedge clk);
        in_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL bp_second_accept: busy=%b in_ready=%b required 1 0", busy[0], in_ready[0]);
        end
        for (int n = 0; n < 40 && out_valid[0] !== 1'b1; n++) @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++; $display("FAIL bp_second_done: out_valid=%b required 1", out_valid[0]);
        end
        drain(0, "bp_second");
        checks++;
        if (first_exp !== APPB_OUT) begin
            errors++; $display("FAIL model_appb: model %h required %h", first_exp, APPB_OUT);
        end
    endtask

    task automatic test_reset_mid();
        in_data = APPB_IN; in_inv = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || out_data[1] !== '0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            errors++; $display("FAIL reset_mid: vld=%b data=%h rdy=%b busy=%b required 0 0 1 0",
                               out_valid[1], out_data[1], in_ready[1], busy[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
             128'h637c777bf26b6fc53001672bfed7ab76, "post_reset");
        drain(1, "post_reset");
    endtask

    task automatic test_no_inv();
        send(5, {16{8'h63}}, 1'b1, {16{8'hfb}}, "no_inv");
        drain(5, "no_inv");
    endtask

    initial begin
        build_model();
        test_reset();
        test_forward();
        test_inverse();
        test_full_table();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_no_inv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
Parametrised, sequential successor to the combinational SubBytes stage. It applies the AES S-box, or the inverse S-box, to a 128-bit state. It processes LANES bytes per cycle, so S-box area is traded against latency. It sits between AddRoundKey and ShiftRows in the encrypt datapath and, with in_inv set, serves the decrypt datapath. Valid/ready handshakes are used on both sides. S-box contents are synthesised constant tables inside the block; no external memory file is used.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is a compile-time error.
ENABLE_INV, 1, 1 = inverse S-box tables instantiated and in_inv honoured; 0 = forward only, in_inv ignored.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data/in_inv valid.
in_ready  output  1  block can accept a state.
in_data  input  128  state; byte i = bits [8i+7:8i].
in_inv  input  1  1 = inverse SubBytes for this state.
out_valid  output  1  out_data holds a completed result.
out_ready  input  1  downstream accepts result.
out_data  output  128  substituted state, same byte ordering.
busy  output  1  high in PROC or DONE.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_data = 0; byte counter = 0; latched mode = 0.
- FSM states: IDLE, PROC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: latch in_data into the working register, latch mode = in_inv & ENABLE_INV, clear the counter, go to PROC.
- PROC:
  - in_ready = 0.
  - Each cycle, bytes cnt .. cnt+LANES-1 of the working register are replaced in place by S[b] (forward) or S^-1[b] (inverse); then cnt += LANES.
  - When the final group (cnt = 16-LANES) is written, go to DONE.
  - PROC lasts exactly 16/LANES cycles.
  - LANES = 16 gives a single PROC cycle.
- DONE:
  - out_valid = 1; out_data = working register, held stable until accepted.
  - On out_ready at an edge: out_valid drops and the FSM returns to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of consecutive states.
- Latency: accept at edge k; out_valid is high after edge k + 16/LANES.
- Throughput: one state per (16/LANES + 2) cycles, with out_ready held high.
- Backpressure: out_ready may be low indefinitely. out_data and out_valid must not change while out_valid = 1 and out_ready = 0.
- in_valid deasserted in IDLE: no state change. in_data and in_inv are don't-care outside an accepting edge.
- in_inv changing during PROC or DONE: no effect; the mode is latched at accept.
- ENABLE_INV = 0: in_inv is ignored, the inverse tables are absent, and the result is always forward.
- Counter: wraps to 0 at DONE entry; never indexes beyond byte 15.
- Reset asserted mid-PROC or in DONE:
  - Immediate return to reset values; the in-flight state is discarded; out_valid falls asynchronously.
  - After rst_n deasserts, the first accepted state produces a correct result.
- Tables: forward S per FIPS-197 (S[00]=63, S[01]=7C, S[53]=ED, S[FF]=16). Inverse is the exact inverse permutation.

Test Plan:
- Forward, FIPS-197 App.B: LANES=4, in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0 -> out_data=d42711aee0bf98f1b8b45de51e415230; out_valid exactly 4 cycles after accept.
- Inverse round-trip: feed d42711aee0bf98f1b8b45de51e415230 with in_inv=1 -> 193de3bea0f4e22b9ac68d2ae9f84808. Also all-00 state forward -> all-63, then all-63 inverse -> all-00.
- Parameter sweep: LANES = 1, 2, 8, 16 on the App.B vector. Each must give the same result, with latency 16, 8, 2 and 1 cycles respectively, and in_ready low throughout.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_data is stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready -> handshake, IDLE next cycle, then the second state is accepted.
- Reset mid-operation: assert rst_n=0 during cycle 2 of PROC (LANES=1). out_valid=0, out_data=0, in_ready=1 immediately. The next state 00010203..0f gives 637c777bf26b6fc53001672bfed7ab76.
- ENABLE_INV=0 build: in_inv=1 with all-63 input -> all-fb (the forward result), confirming in_inv is ignored.
